// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: synchronises ps2_clk, deframes 11-bit frames,
// checks start/stop/parity and queues good scancodes in a small FIFO.
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    r_ps2_clk_sync;
  logic [3:0]    r_cnt;
  logic [9:0]    r_buf;
  logic [TW-1:0] r_tmo;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic          r_overflow;
  logic          r_frame_err;

  logic w_fall;
  logic w_stop_edge;
  logic w_frame_ok;
  logic w_wr_req;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_fall      = (r_ps2_clk_sync[2:1] == 2'b10);
  assign w_stop_edge = w_fall && (r_cnt == 4'd10);
  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  assign w_frame_ok  = ~r_buf[0] & ps2_data & (^r_buf[9:1]);
  assign w_wr_req    = w_stop_edge & w_frame_ok;
  assign w_full      = (r_occ == (AW + 1)'(FIFO_DEPTH));
  assign w_pop       = ~nextdata_n & (r_occ != '0);
  assign w_wr        = w_wr_req & (~w_full | w_pop);

  assign data      = r_mem[r_rd_ptr];
  assign ready     = (r_occ != '0);
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ps2_clk_sync <= 3'b000;
      r_cnt          <= '0;
      r_buf          <= '0;
      r_tmo          <= '0;
      r_frame_err    <= 1'b0;
    end else begin
      r_ps2_clk_sync <= {r_ps2_clk_sync[1:0], ps2_clk};
      r_frame_err    <= w_stop_edge & ~w_frame_ok;
      if (w_fall) begin
        r_tmo <= '0;
        if (r_cnt == 4'd10) begin
          r_cnt <= '0;
        end else begin
          for (int i = 0; i < 10; i++) begin
            if (r_cnt == 4'(i)) r_buf[i] <= ps2_data;
          end
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (r_cnt == '0) begin
        r_tmo <= '0;
      end else if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
        // Keyboard went quiet mid-frame: drop the partial frame silently.
        r_cnt <= '0;
        r_tmo <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_pop)                        r_overflow <= 1'b0;
      else if (w_wr_req && w_full)      r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_buf[8:1];
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames, keeps a queue-level model of
// the FIFO and checks every pop plus periodic status snapshots.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 10;

  logic       clk        = 1'b0;
  logic       clrn       = 1'b0;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;

  ps2_keyboard_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .nextdata_n (nextdata_n),
    .data       (data),
    .ready      (ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  bit         model_ovf = 1'b0;
  int         exp_err   = 0;
  int         err_seen  = 0;
  int         tests     = 0;
  int         fails     = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: all inputs change 1 ns after a rising edge
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_stop);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(H);
      ps2_clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        // Two synchroniser stages later the DUT acts on the stop edge.
        wait_clk(2);
        nextdata_n = 1'b0;
        wait_clk(1);
        nextdata_n = 1'b1;
        wait_clk(H - 3);
      end else begin
        wait_clk(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit pop_at_stop);
    logic par;
    logic [10:0] bits;
    par  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
    par  = par ^ bad_par;
    bits = {~bad_stop, par, d, 1'b0};
    send_bits(bits, 11, pop_at_stop);
    wait_clk(4);
    if (bad_par || bad_stop)      exp_err++;
    else if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else                           model_ovf = 1'b1;
  endtask

  task automatic pop();
    nextdata_n = 1'b0;
    wait_clk(1);
    nextdata_n = 1'b1;
    wait_clk(1);
  endtask

  task automatic check_state();
    @(negedge clk);
    chk("ready", int'(ready), int'(exp_q.size() != 0));
    chk("overflow", int'(overflow), int'(model_ovf));
    chk("frame_err_count", err_seen, exp_err);
    if (exp_q.size() != 0) chk("head_data", int'(data), int'(exp_q[0]));
    wait_clk(1);
  endtask

  // scoreboard monitor: every DUT pop is compared with the model head
  always @(negedge clk) begin
    if (clrn) begin
      if (frame_err) err_seen++;
      if (!nextdata_n && ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got %0h expected empty at %0t", data, $time);
        end else begin
          chk("pop_data", int'(data), int'(exp_q.pop_front()));
          model_ovf = 1'b0;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] nine [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  initial begin
    wait_clk(3);
    check_state();
    clrn = 1'b1;
    wait_clk(3);

    // single frame then pop
    send_frame(8'h1C, 0, 0, 0);
    check_state();
    pop();
    check_state();

    // break prefix followed by make code
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0);
    check_state();
    pop();
    pop();
    check_state();

    // bad parity, then bad stop bit
    send_frame(8'h32, 1, 0, 0);
    check_state();
    send_frame(8'h32, 0, 1, 0);
    check_state();

    // overflow: ninth frame dropped
    for (int i = 0; i < 9; i++) send_frame(nine[i], 0, 0, 0);
    check_state();
    pop();
    check_state();
    for (int i = 0; i < 7; i++) pop();
    check_state();

    // partial frame abandoned by timeout
    send_bits(11'b000_0011_0010, 5, 0);
    wait_clk(TMO + 50);
    send_frame(8'h32, 0, 0, 0);
    check_state();
    pop();
    check_state();

    // reset in the middle of a frame
    send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
    send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
    send_bits(11'b110_0100_0100, 6, 0);
    clrn = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    check_state();
    wait_clk(2);
    clrn = 1'b1;
    wait_clk(3);
    send_frame(8'h45, 0, 0, 0);
    check_state();
    pop();

    // write and pop on the same cycle with the FIFO full
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 0, 0, 0);
    send_frame(8'hA5, 0, 0, 1);
    check_state();
    for (int i = 0; i < DEPTH; i++) pop();
    check_state();

    // randomized mix
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 9) < 6)
        send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      else
        pop();
      check_state();
    end

    while (exp_q.size() != 0 && tests < 100000) pop();
    pop();
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
